// File: rtl/pht_gshare_if.sv
// ----------------------------------------------------------------------------
// pht_gshare_if
//   Groups the prediction and resolution handshakes of the pattern history
//   table into one bundle.
//
//   Signals:
//     predict     requester -> PHT  prediction request
//     pred_index  requester -> PHT  raw fetch index for the request
//     FINAL_PRED  PHT -> requester  registered prediction (1 = taken)
//     pred_valid  PHT -> requester  one-cycle pulse qualifying FINAL_PRED/pred_row
//     pred_row    PHT -> requester  table row actually read
//     resolve     resolver -> PHT   update request
//     res_row     resolver -> PHT   row to update (pred_row returned earlier)
//     incr        resolver -> PHT   branch taken
//     decr        resolver -> PHT   branch not taken
//
//   Modports: master = requester/resolver side, slave = the table itself.
// ----------------------------------------------------------------------------
interface pht_gshare_if #(
    parameter int W_IND = 4
);
    logic             predict;
    logic [W_IND-1:0] pred_index;
    logic             FINAL_PRED;
    logic             pred_valid;
    logic [W_IND-1:0] pred_row;
    logic             resolve;
    logic [W_IND-1:0] res_row;
    logic             incr;
    logic             decr;

    modport master (
        output predict, pred_index, resolve, res_row, incr, decr,
        input  FINAL_PRED, pred_valid, pred_row
    );

    modport slave (
        input  predict, pred_index, resolve, res_row, incr, decr,
        output FINAL_PRED, pred_valid, pred_row
    );
endinterface

// File: rtl/pht_gshare.sv
// ----------------------------------------------------------------------------
// pht_gshare
//   Pattern history table of 2**W_IND saturating counters (CNT_W bits each)
//   with a global history register. The prediction is the MSB of the selected
//   counter and is registered; a resolve to the row being read in the same
//   cycle is forwarded into the prediction.
//
//   Optional feature macro: PHT_GSHARE_EN
//     defined   : row = pred_index XOR zero-extended GHR (gshare)
//     undefined : row = pred_index (bimodal); GHR still maintained for debug
//
//   Ports:
//     clk   in   clock, all state updates on its rising edge
//     rst   in   synchronous active-high reset
//     bus   slave modport of pht_gshare_if (predict/resolve handshakes)
//     ghr   out  current global history
// ----------------------------------------------------------------------------
module pht_gshare #(
    parameter int W_IND  = 4,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    pht_gshare_if.slave       bus,
    output logic [HIST_W-1:0] ghr
);
    localparam int DEPTH = 2 ** W_IND;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Weakly not-taken: 0111.. pattern, i.e. 2**(CNT_W-1)-1.
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};

    logic [CNT_W-1:0]  table_q [DEPTH];
    logic [HIST_W-1:0] ghr_q;
    logic              pred_q;
    logic              valid_q;
    logic [W_IND-1:0]  row_q;

    logic              upd_en;
    logic [CNT_W-1:0]  upd_cnt;
    logic [W_IND-1:0]  row;
    logic [CNT_W-1:0]  rd_cnt;
    logic [HIST_W-1:0] ghr_next;

`ifdef PHT_GSHARE_EN
    logic [W_IND-1:0]  ghr_ext;
`endif

    // Only a resolve with exactly one direction bit is a real update.
    assign upd_en = bus.resolve & (bus.incr ^ bus.decr);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        upd_cnt = table_q[bus.res_row];
        if (bus.incr) begin
            if (upd_cnt != CNT_MAX) upd_cnt = upd_cnt + 1'b1;
        end else begin
            if (upd_cnt != '0) upd_cnt = upd_cnt - 1'b1;
        end
    end

    // Shift in the outcome; truncating {ghr, incr} keeps the low HIST_W bits,
    // which also covers HIST_W = 1.
    assign ghr_next = HIST_W'({ghr_q, bus.incr});

`ifdef PHT_GSHARE_EN
    always_comb begin
        ghr_ext = '0;
        ghr_ext[HIST_W-1:0] = ghr_q;
    end
    // XOR of two W_IND-bit values wraps modulo the table depth by construction.
    assign row = bus.pred_index ^ ghr_ext;
`else
    assign row = bus.pred_index;
`endif

    // Forward the post-update value when the resolve hits the row being read.
    assign rd_cnt = (upd_en && (row == bus.res_row)) ? upd_cnt : table_q[row];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is reset in full on one edge, so it is built
            // from flops rather than a RAM macro (RAMs cannot be cleared).
            for (int i = 0; i < DEPTH; i++) table_q[i] <= CNT_INIT;
            ghr_q   <= '0;
            pred_q  <= 1'b0;
            valid_q <= 1'b0;
            row_q   <= '0;
        end else begin
            if (upd_en) begin
                table_q[bus.res_row] <= upd_cnt;
                ghr_q                <= ghr_next;
            end
            valid_q <= bus.predict;
            if (bus.predict) begin
                pred_q <= rd_cnt[CNT_W-1];
                row_q  <= row;
            end
        end
    end

    assign bus.FINAL_PRED = pred_q;
    assign bus.pred_valid = valid_q;
    assign bus.pred_row   = row_q;
    assign ghr            = ghr_q;
endmodule

// File: tb/tb_pht_gshare.sv
// ----------------------------------------------------------------------------
// tb_pht_gshare
//   Directed bench for pht_gshare (W_IND=4, CNT_W=2, HIST_W=4). A behavioural
//   model of the table (integer counters, integer history) tracks the expected
//   outputs and is compared against the DUT every cycle; directed steps add
//   hand-computed literal expectations. Works for both the bimodal build and
//   the PHT_GSHARE_EN build.
// ----------------------------------------------------------------------------
module tb_pht_gshare;
    localparam int W_IND    = 4;
    localparam int CNT_W    = 2;
    localparam int HIST_W   = 4;
    localparam int DEPTH    = 1 << W_IND;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int CNT_INIT = (1 << (CNT_W - 1)) - 1;
`ifdef PHT_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [HIST_W-1:0] ghr;

    int n_checks = 0;
    int n_fail   = 0;

    pht_gshare_if #(.W_IND(W_IND)) bus ();

    pht_gshare #(.W_IND(W_IND), .CNT_W(CNT_W), .HIST_W(HIST_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .ghr (ghr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [DEPTH];
    int m_ghr   = 0;
    int m_valid = 0;
    int m_pred  = 0;
    int m_row   = 0;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        int r;
        int c;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_cnt[i] = CNT_INIT;
            m_ghr = 0; m_valid = 0; m_pred = 0; m_row = 0;
            model_live = 1'b1;
        end else begin
            // Row uses the history from before this edge.
            r = GSHARE ? ((int'(bus.pred_index) ^ m_ghr) % DEPTH) : int'(bus.pred_index);
            if (bus.resolve && (bus.incr != bus.decr)) begin
                c = m_cnt[bus.res_row];
                if (bus.incr) c = (c == CNT_MAX) ? c : c + 1;
                else          c = (c == 0) ? 0 : c - 1;
                m_cnt[bus.res_row] = c;
                m_ghr = (m_ghr * 2 + int'(bus.incr)) % (1 << HIST_W);
            end
            // Reading after the update gives same-cycle forwarding.
            m_valid = int'(bus.predict);
            if (bus.predict) begin
                m_pred = (m_cnt[r] >= (1 << (CNT_W - 1))) ? 1 : 0;
                m_row  = r;
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("cmp_pred_valid", 32'(bus.pred_valid), 32'(m_valid));
            check("cmp_final_pred", 32'(bus.FINAL_PRED), 32'(m_pred));
            check("cmp_pred_row",   32'(bus.pred_row),   32'(m_row));
            check("cmp_ghr",        32'(ghr),            32'(m_ghr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W_IND-1:0] idx_for_row(input int r);
        return GSHARE ? W_IND'(r ^ m_ghr) : W_IND'(r);
    endfunction

    task automatic do_predict(input int r);
        bus.predict    = 1'b1;
        bus.pred_index = idx_for_row(r);
        cycle();
        bus.predict    = 1'b0;
    endtask

    task automatic do_resolve(input int r, input logic inc, input logic dec);
        bus.resolve = 1'b1;
        bus.res_row = W_IND'(r);
        bus.incr    = inc;
        bus.decr    = dec;
        cycle();
        bus.resolve = 1'b0;
        bus.incr    = 1'b0;
        bus.decr    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.predict = 1'b0; bus.pred_index = '0;
        bus.resolve = 1'b0; bus.res_row = '0;
        bus.incr = 1'b0; bus.decr = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state.
        check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
        check("rst_final_pred", 32'(bus.FINAL_PRED), 32'd0);
        check("rst_pred_row",   32'(bus.pred_row),   32'd0);
        check("rst_ghr",        32'(ghr),            32'd0);

        // Back-to-back predicts over every row: all weakly not-taken.
        bus.predict = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.pred_index = W_IND'(i);
            cycle();
            check("sweep_valid", 32'(bus.pred_valid), 32'd1);
            check("sweep_pred",  32'(bus.FINAL_PRED), 32'd0);
            check("sweep_row",   32'(bus.pred_row),   32'(i));
        end
        bus.predict = 1'b0;
        cycle();
        check("hold_valid", 32'(bus.pred_valid), 32'd0);
        check("hold_row",   32'(bus.pred_row),   32'd15);

        // Saturating counter on row 5.
        do_resolve(5, 1, 0);
        do_resolve(5, 1, 0);                       // 01 -> 10 -> 11
        do_predict(5); check("r5_after_2inc", 32'(bus.FINAL_PRED), 32'd1);
        do_resolve(5, 1, 0);                       // saturate at 11
        do_resolve(5, 0, 1);                       // 10
        do_predict(5); check("r5_sat_hi", 32'(bus.FINAL_PRED), 32'd1);
        do_resolve(5, 0, 1);
        do_resolve(5, 0, 1);                       // 00
        do_predict(5); check("r5_at_zero", 32'(bus.FINAL_PRED), 32'd0);
        do_resolve(5, 0, 1);                       // stays 00
        do_predict(5); check("r5_sat_lo", 32'(bus.FINAL_PRED), 32'd0);
        do_resolve(5, 1, 0);                       // 01
        do_predict(5); check("r5_lo_plus1", 32'(bus.FINAL_PRED), 32'd0);

        // Same-cycle forwarding on row 3 (at 01).
        bus.predict    = 1'b1;
        bus.pred_index = idx_for_row(3);
        bus.resolve    = 1'b1; bus.res_row = 4'd3; bus.incr = 1'b1; bus.decr = 1'b0;
        cycle();
        bus.predict = 1'b0; bus.resolve = 1'b0; bus.incr = 1'b0;
        check("fwd_valid", 32'(bus.pred_valid), 32'd1);
        check("fwd_pred",  32'(bus.FINAL_PRED), 32'd1);

        // History sequence from a clean state.
        do_reset();
        do_resolve(1, 1, 0); check("ghr_1", 32'(ghr), 32'h1);
        do_resolve(2, 1, 0); check("ghr_2", 32'(ghr), 32'h3);
        do_resolve(6, 0, 1); check("ghr_3", 32'(ghr), 32'h6);
        bus.predict = 1'b1; bus.pred_index = 4'hA;
        cycle();
        bus.predict = 1'b0;
        check("hash_row", 32'(bus.pred_row), GSHARE ? 32'hC : 32'hA);
        check("hash_pred", 32'(bus.FINAL_PRED), 32'd0);

        // No-op resolves on row 7 leave counter and history alone.
        do_resolve(7, 1, 1); check("noop11_ghr", 32'(ghr), 32'h6);
        do_resolve(7, 0, 0); check("noop00_ghr", 32'(ghr), 32'h6);
        do_resolve(7, 1, 0);                       // 01 -> 10 if untouched
        do_predict(7); check("noop_then_inc", 32'(bus.FINAL_PRED), 32'd1);
        do_resolve(7, 0, 1);                       // back to 01
        do_predict(7); check("noop_then_dec", 32'(bus.FINAL_PRED), 32'd0);

        // Reset mid-operation with a predict in flight.
        do_resolve(9, 1, 0);
        do_resolve(9, 1, 0);
        do_predict(9); check("r9_trained", 32'(bus.FINAL_PRED), 32'd1);
        rst = 1'b1;
        bus.predict = 1'b1; bus.pred_index = idx_for_row(9);
        cycle();
        rst = 1'b0;
        bus.predict = 1'b0;
        check("midrst_valid", 32'(bus.pred_valid), 32'd0);
        check("midrst_ghr",   32'(ghr),            32'd0);
        bus.predict = 1'b1; bus.pred_index = 4'd9;
        cycle();
        bus.predict = 1'b0;
        check("post_rst_pred", 32'(bus.FINAL_PRED), 32'd0);
        check("post_rst_row",  32'(bus.pred_row),   32'd9);
        check("post_rst_ghr",  32'(ghr),            32'd0);

        cycle();
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
